// File: rtl/btn_debounce_if.sv
// Button bank bus: raw pins and slow sampling clock in, filtered levels and event pulses out.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = 4
);
    logic             clk_slow;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic             sample_tick;

    // Stimulus / front-end side
    modport master (
        output clk_slow,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  sample_tick
    );

    // Debouncer side
    modport slave (
        input  clk_slow,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output sample_tick
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronises active-low pins and the slow sampling clock,
// filters each button with a consecutive-sample counter and emits clean levels plus
// one-cycle press / release / long-press pulses.
// Optional feature macro: BTN_LONG_PRESS_EN (HELD state, hold counters, btn_long).
module btn_debounce #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned LONG_SAMPLES   = 12
) (
    input logic          clk_in,
    input logic          rst_n,
    btn_debounce_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_SAMPLES + 1);
    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;
`endif

    // Reject parameter sets that would make the counters meaningless
    if (STABLE_SAMPLES < 1 || LONG_SAMPLES <= STABLE_SAMPLES) begin : g_bad_params
        $error("btn_debounce: need STABLE_SAMPLES >= 1 and LONG_SAMPLES > STABLE_SAMPLES");
    end

    logic [N_BTN-1:0] raw_s1, raw_s2;
    logic             slow_s1, slow_s2, slow_s3;
    logic             tick_q;

    state_t           state_q [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [N_BTN-1:0] level_q, press_q, release_q;
    logic [N_BTN-1:0] press_acc_c, release_acc_c;
`ifdef BTN_LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [N_BTN-1:0]  long_q;
`endif

    // Two-flop synchronisers for pins (reset to released) and slow clock, plus edge flop
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            raw_s1  <= '1;
            raw_s2  <= '1;
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            raw_s1  <= bus.btn_raw;
            raw_s2  <= raw_s1;
            slow_s1 <= bus.clk_slow;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            tick_q  <= slow_s2 & ~slow_s3;
        end
    end

    // A sample completes a run when it disagrees with the current level and the run is one short
    always_comb begin
        press_acc_c   = '0;
        release_acc_c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_acc_c[i]   = ~raw_s2[i] && (cnt_q[i] == CNT_W'(STABLE_SAMPLES - 1));
            release_acc_c[i] =  raw_s2[i] && (cnt_q[i] == CNT_W'(STABLE_SAMPLES - 1));
        end
    end

    // Per-button filter FSM; advances only on sample_tick, pulses default low every cycle
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_RELEASED;
                cnt_q[i]   <= '0;
            end
`ifdef BTN_LONG_PRESS_EN
            long_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
`endif
        end else begin
            press_q   <= '0;
            release_q <= '0;
`ifdef BTN_LONG_PRESS_EN
            long_q    <= '0;
`endif
            if (tick_q) begin
                for (int i = 0; i < N_BTN; i++) begin
                    if (state_q[i] == ST_RELEASED) begin
                        if (press_acc_c[i]) begin
                            state_q[i] <= ST_PRESSED;
                            cnt_q[i]   <= '0;
                            press_q[i] <= 1'b1;
                            level_q[i] <= 1'b1;
                        end else if (~raw_s2[i]) begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        // PRESSED and HELD share release counting
                        if (release_acc_c[i]) begin
                            state_q[i]   <= ST_RELEASED;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                            level_q[i]   <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                            hold_q[i]    <= '0;
`endif
                        end else if (raw_s2[i]) begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end else begin
                            cnt_q[i] <= '0;
                        end
`ifdef BTN_LONG_PRESS_EN
                        // Release wins over a long-press reached on the same tick
                        if (state_q[i] == ST_PRESSED && !release_acc_c[i]) begin
                            if (hold_q[i] == HOLD_W'(LONG_SAMPLES - 1)) begin
                                state_q[i] <= ST_HELD;
                                hold_q[i]  <= HOLD_W'(LONG_SAMPLES);
                                long_q[i]  <= 1'b1;
                            end else begin
                                hold_q[i] <= hold_q[i] + HOLD_W'(1);
                            end
                        end
`endif
                    end
                end
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.sample_tick = tick_q;
`ifdef BTN_LONG_PRESS_EN
    assign bus.btn_long    = long_q;
`else
    assign bus.btn_long    = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N_BTN=4, STABLE_SAMPLES=3, LONG_SAMPLES=12).
module tb_btn_debounce;
`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    btn_debounce_if #(.N_BTN(4)) bus ();

    btn_debounce #(
        .N_BTN(4),
        .STABLE_SAMPLES(3),
        .LONG_SAMPLES(12)
    ) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Posedge counter used to time pulses against ticks
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Event recorder, sampled on the falling edge
    logic       clr_req = 1'b0;
    int         tick_n = 0, tick_cyc = 0, bad_n = 0;
    int         press_n[4], release_n[4], long_n[4];
    int         press_cyc[4], release_cyc[4], long_cyc[4];
    logic [3:0] press_vec = '0, prev_press = '0, prev_rel = '0, prev_long = '0;
    logic       prev_tick = 1'b0;
    int         drive_cyc = 0;

    always @(negedge clk) begin
        if (clr_req) begin
            tick_n    = 0;
            press_vec = '0;
            for (int i = 0; i < 4; i++) begin
                press_n[i] = 0; release_n[i] = 0; long_n[i] = 0;
                press_cyc[i] = 0; release_cyc[i] = 0; long_cyc[i] = 0;
            end
        end else begin
            if (bus.sample_tick === 1'b1) begin tick_n++; tick_cyc = cyc; end
            for (int i = 0; i < 4; i++) begin
                if (bus.btn_press[i] === 1'b1)   begin press_n[i]++;   press_cyc[i] = cyc;   end
                if (bus.btn_release[i] === 1'b1) begin release_n[i]++; release_cyc[i] = cyc; end
                if (bus.btn_long[i] === 1'b1)    begin long_n[i]++;    long_cyc[i] = cyc;    end
            end
            if (bus.btn_press != 4'b0000) press_vec = bus.btn_press;
        end
        // Protocol invariants: one-cycle pulses, no press/release or press/long overlap
        if ((bus.btn_press & bus.btn_release) != 4'b0000 || (bus.btn_press & bus.btn_long) != 4'b0000 ||
            (bus.btn_press & prev_press) != 4'b0000 || (bus.btn_release & prev_rel) != 4'b0000 ||
            (bus.btn_long & prev_long) != 4'b0000 || (bus.sample_tick && prev_tick))
            bad_n++;
        prev_press = bus.btn_press;
        prev_rel   = bus.btn_release;
        prev_long  = bus.btn_long;
        prev_tick  = bus.sample_tick;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    // One slow-clock period: rising edge, 4 cycles high, 4 cycles low
    task automatic tick();
        @(posedge clk);
        #1 bus.clk_slow = 1'b1;
        drive_cyc = cyc;
        repeat (4) @(posedge clk);
        #1 bus.clk_slow = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            press_n[i] = 0; release_n[i] = 0; long_n[i] = 0;
            press_cyc[i] = 0; release_cyc[i] = 0; long_cyc[i] = 0;
        end
        bus.clk_slow = 1'b0;
        bus.btn_raw  = 4'b0000;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state with pins reading pressed
        check("rst_level",   32'(bus.btn_level),   32'h0);
        check("rst_press",   32'(bus.btn_press),   32'h0);
        check("rst_release", 32'(bus.btn_release), 32'h0);
        check("rst_long",    32'(bus.btn_long),    32'h0);
        check("rst_tick",    32'(bus.sample_tick), 32'h0);

        // Idle: all released, 10 ticks, nothing happens
        bus.btn_raw = 4'b1111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        ticks(10);
        check("idle_ticks",    32'(tick_n), 32'd10);
        check("tick_latency",  32'(tick_cyc - drive_cyc), 32'd3);
        check("idle_press",    32'(press_n[0] + press_n[1] + press_n[2] + press_n[3]), 32'd0);
        check("idle_release",  32'(release_n[0] + release_n[1] + release_n[2] + release_n[3]), 32'd0);
        check("idle_level",    32'(bus.btn_level), 32'h0);

        // Clean press on btn0
        clear_counts();
        bus.btn_raw = 4'b1110;
        ticks(2);
        check("b0_press_early", 32'(press_n[0]), 32'd0);
        tick();
        check("b0_press_n",   32'(press_n[0]), 32'd1);
        check("b0_press_lat", 32'(press_cyc[0] - tick_cyc), 32'd1);
        check("b0_level",     32'(bus.btn_level), 32'h1);
        tick();
        check("b0_press_once", 32'(press_n[0]), 32'd1);

        // Bounce on btn1: 2 pressed, 1 released, 3 pressed
        clear_counts();
        bus.btn_raw = 4'b1100;
        ticks(2);
        bus.btn_raw = 4'b1110;
        tick();
        bus.btn_raw = 4'b1100;
        ticks(2);
        check("b1_press_early", 32'(press_n[1]), 32'd0);
        tick();
        check("b1_press_n",   32'(press_n[1]), 32'd1);
        check("b1_press_lat", 32'(press_cyc[1] - tick_cyc), 32'd1);
        check("b1_release_n", 32'(release_n[1]), 32'd0);
        check("b1_level",     32'(bus.btn_level), 32'h3);

        // Release btn0 and btn1 together
        clear_counts();
        bus.btn_raw = 4'b1111;
        ticks(3);
        check("b01_release0", 32'(release_n[0]), 32'd1);
        check("b01_release1", 32'(release_n[1]), 32'd1);
        check("b01_long",     32'(long_n[0] + long_n[1]), 32'd0);
        check("b01_level",    32'(bus.btn_level), 32'h0);

        // Long press on btn2
        clear_counts();
        bus.btn_raw = 4'b1011;
        ticks(3);
        check("b2_press_n",   32'(press_n[2]), 32'd1);
        check("b2_press_lat", 32'(press_cyc[2] - tick_cyc), 32'd1);
        ticks(11);
        check("b2_long_early", 32'(long_n[2]), 32'd0);
        tick();
        check("b2_long_n15", 32'(long_n[2]), 32'(LONG_EXP));
`ifdef BTN_LONG_PRESS_EN
        check("b2_long_lat", 32'(long_cyc[2] - tick_cyc), 32'd1);
`endif
        ticks(5);
        check("b2_long_once",  32'(long_n[2]), 32'(LONG_EXP));
        check("b2_press_once", 32'(press_n[2]), 32'd1);
        check("b2_level",      32'(bus.btn_level), 32'h4);
        bus.btn_raw = 4'b1111;
        ticks(2);
        check("b2_release_early", 32'(release_n[2]), 32'd0);
        tick();
        check("b2_release_n",   32'(release_n[2]), 32'd1);
        check("b2_release_lat", 32'(release_cyc[2] - tick_cyc), 32'd1);
        check("b2_level_off",   32'(bus.btn_level), 32'h0);

        // Simultaneous press of btn0 and btn3
        clear_counts();
        bus.btn_raw = 4'b0110;
        ticks(3);
        check("sim_vec",   32'(press_vec), 32'h9);
        check("sim_same",  32'(press_cyc[3] - press_cyc[0]), 32'd0);
        check("sim_level", 32'(bus.btn_level), 32'h9);
        bus.btn_raw = 4'b1111;
        ticks(3);
        check("sim_release", 32'(release_n[0] + release_n[3]), 32'd2);

        // Reset while btn2 is held, button kept pressed through reset
        clear_counts();
        bus.btn_raw = 4'b1011;
        ticks(15);
        check("mid_level", 32'(bus.btn_level), 32'h4);
        check("mid_long",  32'(long_n[2]), 32'(LONG_EXP));
        #3 rst_n = 1'b0;
        #1;
        check("async_level", 32'(bus.btn_level), 32'h0);
        check("async_long",  32'(bus.btn_long), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        ticks(2);
        check("post_press_early", 32'(press_n[2]), 32'd0);
        tick();
        check("post_press_n",   32'(press_n[2]), 32'd1);
        check("post_press_lat", 32'(press_cyc[2] - tick_cyc), 32'd1);
        check("post_release",   32'(release_n[2]), 32'd0);
        check("post_level",     32'(bus.btn_level), 32'h4);

        check("invariants", 32'(bad_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
